dcache_vldrty_init_ctrl: RTL and testbench

Sequencer and arbiter for the data cache valid/dirty SRAM: it sweeps every index to clear all valid and dirty bits, either automatically after reset or on an explicit invalidate request. It sits between the tag-compare arbiter (upstream) and the valid/dirty `tc_sram`. It stalls upstream access for the duration of a sweep and passes accesses through transparently otherwise.

---
 rtl/dcache_vldrty_init_ctrl.sv | 133 +++++++++++++
 tb/tb_dcache_vldrty_init_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_vldrty_init_ctrl.sv
// Valid/dirty SRAM init and invalidate sequencer for the data cache.
// Sweeps every index, writing zero to all ways to clear valid and dirty bits.
// A sweep starts after reset (optional) or on an invalidate request.
// Outside a sweep, upstream accesses pass straight through to the SRAM.
module dcache_vldrty_init_ctrl #(
    parameter int unsigned NUM_WORDS     = 256,
    parameter int unsigned SET_ASSOC     = 8,
    parameter bit          INIT_ON_RESET = 1'b1,
    localparam int unsigned IDX_W        = $clog2(NUM_WORDS),
    localparam int unsigned VD_W         = 8 * SET_ASSOC
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // invalidate handshake
    input  logic                 inv_req_i,
    output logic                 inv_ack_o,
    output logic                 busy_o,
    // upstream (tag-compare arbiter) side
    input  logic                 up_req_i,
    output logic                 up_gnt_o,
    input  logic                 up_we_i,
    input  logic [IDX_W-1:0]     up_addr_i,
    input  logic [VD_W-1:0]      up_wdata_i,
    input  logic [SET_ASSOC-1:0] up_be_i,
    output logic [VD_W-1:0]      up_rdata_o,
    // valid/dirty SRAM side
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [IDX_W-1:0]     sram_addr_o,
    output logic [VD_W-1:0]      sram_wdata_o,
    output logic [SET_ASSOC-1:0] sram_be_o,
    input  logic [VD_W-1:0]      sram_rdata_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSweep = 2'd1;
    localparam logic [1:0] StAck   = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    // Set when the current sweep owes an acknowledge to the requester.
    logic             pend_q, pend_d;

    // Next-state: sequence the sweep and record who asked for it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            StIdle: begin
                if (inv_req_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end
            end
            StSweep: begin
                // A request raised mid-sweep is served by this same sweep.
                if (inv_req_i) begin
                    pend_d = 1'b1;
                end
                // Free-running increment wraps to zero after the last index.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                // The requester still holds inv_req_i here; it is not relatched.
                state_d = StIdle;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset optionally launches a sweep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT_ON_RESET ? StSweep : StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Output mux: pass-through by default, sweep writes override, reset gates all.
    always_comb begin
        sram_req_o   = up_req_i;
        sram_we_o    = up_we_i;
        sram_addr_o  = up_addr_i;
        sram_wdata_o = up_wdata_i;
        sram_be_o    = up_be_i;
        up_gnt_o     = up_req_i;
        inv_ack_o    = 1'b0;
        busy_o       = (state_q != StIdle) | pend_q;

        case (state_q)
            StSweep: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = cnt_q;
                sram_wdata_o = '0;
                sram_be_o    = '1;
                up_gnt_o     = 1'b0;
            end
            StAck: begin
                inv_ack_o = pend_q;
            end
            default: begin
            end
        endcase

        if (rst_i) begin
            sram_req_o = 1'b0;
            up_gnt_o   = 1'b0;
            inv_ack_o  = 1'b0;
            busy_o     = INIT_ON_RESET;
        end
    end

    assign up_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_dcache_vldrty_init_ctrl.sv
// Directed bench for dcache_vldrty_init_ctrl with a small behavioural SRAM.
// One instance sweeps on reset, a second one comes out of reset idle.
module tb_dcache_vldrty_init_ctrl;

    localparam int unsigned NW = 16;
    localparam int unsigned SA = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance with INIT_ON_RESET = 1
    logic          rst, inv_req, inv_ack, busy;
    logic          up_req, up_gnt, up_we;
    logic [IW-1:0] up_addr;
    logic [DW-1:0] up_wdata, up_rdata;
    logic [SA-1:0] up_be;
    logic          sram_req, sram_we;
    logic [IW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [SA-1:0] sram_be;
    logic [DW-1:0] sram_rdata;

    // Instance with INIT_ON_RESET = 0
    logic          rst0, inv_req0, inv_ack0, busy0;
    logic          up_req0, up_gnt0, up_we0;
    logic [IW-1:0] up_addr0;
    logic [DW-1:0] up_wdata0, up_rdata0;
    logic [SA-1:0] up_be0;
    logic          sram_req0, sram_we0;
    logic [IW-1:0] sram_addr0;
    logic [DW-1:0] sram_wdata0;
    logic [SA-1:0] sram_be0;
    logic [DW-1:0] sram_rdata0;

    dcache_vldrty_init_ctrl #(
        .NUM_WORDS    (NW),
        .SET_ASSOC    (SA),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .inv_req_i   (inv_req),
        .inv_ack_o   (inv_ack),
        .busy_o      (busy),
        .up_req_i    (up_req),
        .up_gnt_o    (up_gnt),
        .up_we_i     (up_we),
        .up_addr_i   (up_addr),
        .up_wdata_i  (up_wdata),
        .up_be_i     (up_be),
        .up_rdata_o  (up_rdata),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata)
    );

    dcache_vldrty_init_ctrl #(
        .NUM_WORDS    (NW),
        .SET_ASSOC    (SA),
        .INIT_ON_RESET(1'b0)
    ) dut0 (
        .clk_i       (clk),
        .rst_i       (rst0),
        .inv_req_i   (inv_req0),
        .inv_ack_o   (inv_ack0),
        .busy_o      (busy0),
        .up_req_i    (up_req0),
        .up_gnt_o    (up_gnt0),
        .up_we_i     (up_we0),
        .up_addr_i   (up_addr0),
        .up_wdata_i  (up_wdata0),
        .up_be_i     (up_be0),
        .up_rdata_o  (up_rdata0),
        .sram_req_o  (sram_req0),
        .sram_we_o   (sram_we0),
        .sram_addr_o (sram_addr0),
        .sram_wdata_o(sram_wdata0),
        .sram_be_o   (sram_be0),
        .sram_rdata_i(sram_rdata0)
    );

    assign sram_rdata0 = '0;

    // Behavioural SRAM: byte-enabled writes, one-cycle read latency.
    logic [DW-1:0] mem [NW];
    logic          preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) mem[i] <= '1;
            sram_rdata <= '0;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < SA; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int   lat;
    logic got_ack;
    logic ack_seen;
    logic req_seen;

    initial begin
        rst = 1'b1; inv_req = 1'b0;
        up_req = 1'b0; up_we = 1'b0; up_addr = '0; up_wdata = '0; up_be = '0;
        rst0 = 1'b1; inv_req0 = 1'b0;
        up_req0 = 1'b0; up_we0 = 1'b0; up_addr0 = '0; up_wdata0 = '0; up_be0 = '0;
        preload = 1'b1;

        // Reset outputs, with an upstream read to address 3 already held
        up_req = 1'b1; up_addr = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            preload = 1'b0;
            #1;
            check_eq("rst_sram_req", sram_req, 1'b0);
            check_eq("rst_gnt", up_gnt, 1'b0);
            check_eq("rst_ack", inv_ack, 1'b0);
            check_eq("rst_busy", busy, 1'b1);
            check_eq("rst0_busy", busy0, 1'b0);
        end

        // Reset-initiated sweep: 16 clearing writes, upstream stalled
        step();
        rst = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (i != 0) step();
            #1;
            check_eq("init_req_we", {sram_req, sram_we}, 2'b11);
            check_eq("init_addr", sram_addr, i);
            check_eq("init_wdata", sram_wdata, 64'h0);
            check_eq("init_be", sram_be, 8'hFF);
            check_eq("stall_gnt", up_gnt, 1'b0);
            if (inv_ack) ack_seen = 1'b1;
        end
        step(); #1;
        check_eq("init_ack_cycle_ack", inv_ack, 1'b0);
        check_eq("init_ack_cycle_gnt", up_gnt, 1'b1);
        check_eq("init_ack_cycle_busy", busy, 1'b1);
        check_eq("init_ack_cycle_fwd", {sram_req, sram_we, sram_addr}, {2'b10, 4'd3});
        step();
        up_req = 1'b0;
        #1;
        check_eq("init_idle_busy", busy, 1'b0);
        check_eq("stall_rdata", up_rdata, 64'h0);
        check_eq("init_no_ack", ack_seen, 1'b0);

        // Explicit invalidate: preload address 5, read it back, then invalidate
        step();
        up_req = 1'b1; up_we = 1'b1; up_addr = 4'd5; up_wdata = 64'h0202020202020202;
        up_be = 8'hFF;
        #1;
        check_eq("wr5_gnt", up_gnt, 1'b1);
        check_eq("wr5_fwd", {sram_req, sram_we, sram_addr}, {2'b11, 4'd5});
        step();
        up_we = 1'b0;
        #1;
        check_eq("rd5_gnt", up_gnt, 1'b1);
        step();
        up_req = 1'b0;
        inv_req = 1'b1;
        #1;
        check_eq("rd5_pre_data", up_rdata, 64'h0202020202020202);
        check_eq("inv_T_busy", busy, 1'b0);
        lat = 0;
        got_ack = 1'b0;
        for (int k = 1; k <= 40 && !got_ack; k++) begin
            step(); #1;
            if (inv_ack) begin
                got_ack = 1'b1;
                lat = k;
            end
        end
        check_eq("inv_latency", lat, 17);
        check_eq("inv_ack_busy", busy, 1'b1);
        step();
        inv_req = 1'b0;
        up_req = 1'b1; up_we = 1'b0; up_addr = 4'd5;
        #1;
        check_eq("rd5_post_gnt", up_gnt, 1'b1);
        check_eq("ack_one_cycle", inv_ack, 1'b0);
        step();
        up_req = 1'b0;
        #1;
        check_eq("rd5_post_data", up_rdata, 64'h0);

        // Collision: upstream read and invalidate in the same idle cycle
        up_req = 1'b1; up_we = 1'b0; up_addr = 4'd7; inv_req = 1'b1;
        #1;
        check_eq("coll_gnt", up_gnt, 1'b1);
        check_eq("coll_fwd", {sram_req, sram_we, sram_addr}, {2'b10, 4'd7});
        step();
        up_req = 1'b0;
        #1;
        check_eq("coll_sweep0", {sram_req, sram_we, sram_addr}, {2'b11, 4'd0});
        lat = 0;
        got_ack = 1'b0;
        for (int k = 1; k <= 40 && !got_ack; k++) begin
            step(); #1;
            if (inv_ack) begin
                got_ack = 1'b1;
                lat = k;
            end
        end
        check_eq("coll_latency", lat, 16);
        step();
        inv_req = 1'b0;

        // Request raised at index 7 of a reset-initiated sweep
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rs_addr0", sram_addr, 4'd0);
        for (int i = 1; i <= 7; i++) step();
        #1;
        check_eq("rs_addr7", sram_addr, 4'd7);
        inv_req = 1'b1;
        lat = 0;
        got_ack = 1'b0;
        for (int k = 1; k <= 40 && !got_ack; k++) begin
            step(); #1;
            if (inv_ack) begin
                got_ack = 1'b1;
                lat = k;
            end
        end
        check_eq("rs_req_latency", lat, 9);
        step();
        inv_req = 1'b0;
        req_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            #1;
            if (sram_req || busy) req_seen = 1'b1;
        end
        check_eq("rs_single_sweep", req_seen, 1'b0);

        // Reset at index 9 of an explicit sweep: restart at 0, no ack
        inv_req = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        #1;
        check_eq("mid_addr9", sram_addr, 4'd9);
        rst = 1'b1;
        inv_req = 1'b0;
        #1;
        check_eq("mid_rst_req", sram_req, 1'b0);
        step(); #1;
        check_eq("mid_rst_req2", sram_req, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check_eq("mid_restart", {sram_req, sram_we, sram_addr}, {2'b11, 4'd0});
        ack_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(); #1;
            if (inv_ack) ack_seen = 1'b1;
        end
        check_eq("mid_no_ack", ack_seen, 1'b0);
        check_eq("mid_idle_busy", busy, 1'b0);

        // INIT_ON_RESET = 0: idle after reset, reset mid-sweep aborts
        step();
        rst0 = 1'b0;
        #1;
        check_eq("i0_idle_req", sram_req0, 1'b0);
        check_eq("i0_idle_busy", busy0, 1'b0);
        step(); #1;
        check_eq("i0_no_autosweep", sram_req0, 1'b0);
        inv_req0 = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        #1;
        check_eq("i0_addr9", {sram_req0, sram_addr0}, {1'b1, 4'd9});
        rst0 = 1'b1;
        inv_req0 = 1'b0;
        step();
        step();
        rst0 = 1'b0;
        req_seen = 1'b0;
        ack_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (sram_req0 || busy0) req_seen = 1'b1;
            if (inv_ack0) ack_seen = 1'b1;
            step();
        end
        check_eq("i0_abort_quiet", req_seen, 1'b0);
        check_eq("i0_abort_no_ack", ack_seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
